slot_input: RTL and testbench
=============================

SLOT_INPUT -- requirements
Module: slot_input

Interface
REQ-001 Parameter debounce_max, default 32'h00000001, counts of stable cycles required before a button level is accepted.
REQ-002 Parameter sync_stages, default 2, number of synchroniser flops per raw button input (legal range 2..4).
REQ-003 Parameter hold_cycles, default 32'h0000001E, cycles spent in HOLD after stop before a new start is accepted.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start_btn_n  input  1  raw start button, asynchronous, active-low (pressed = 0).
REQ-007 stop_btn_n  input  1  raw stop button, asynchronous, active-low (pressed = 0).
REQ-008 start  output  1  one-cycle start pulse to the slot stage.
REQ-009 stop  output  1  one-cycle stop pulse to the slot stage.
REQ-010 spinning  output  1  high while in SPIN state.
REQ-011 busy  output  1  high while in HOLD state.

Function
REQ-012 Each raw input passes through sync_stages flops, then is inverted so that pressed = 1 internally.
REQ-013 Debounce: a counter clears on any change of the synchronised level versus the accepted level and increments while they differ; when the count reaches debounce_max the accepted level updates and the counter clears.
REQ-014 The counter saturates at debounce_max and never wraps; its width is 32 bits.
REQ-015 A press event is the accepted level rising 0->1; a release event generates nothing.
REQ-016 FSM states: IDLE, SPIN, HOLD; reset state is IDLE.
REQ-017 IDLE: on a start press event, assert start for exactly one cycle and go to SPIN; stop press events are ignored.
REQ-018 SPIN: on a stop press event, assert stop for exactly one cycle, load the hold counter with hold_cycles and go to HOLD; start press events are ignored.
REQ-019 HOLD: the hold counter decrements each cycle, and at 0 the FSM goes to IDLE; all press events are ignored.
REQ-020 If hold_cycles = 0, HOLD lasts exactly one cycle.
REQ-021 On simultaneous start and stop press events in the same cycle, only the event valid for the current state is honoured.
REQ-022 Outputs are registered; start and stop appear one cycle after the FSM accepts the event, and are never high together.
REQ-023 A button held continuously produces one event only; a new event requires an accepted release, then an accepted press.
REQ-024 Latency from the raw edge to the output pulse is sync_stages + debounce_max + 1 cycles, ±1.

Reset
REQ-025 Reset assertion sets the following values asynchronously: all synchroniser flops to 1 (released), accepted levels to 0, counters to 0, state to IDLE, and start, stop, spinning and busy to 0.
REQ-026 Reset deassertion mid-press produces no event until the button is released and pressed again.
REQ-027 Reset asserted in SPIN or HOLD returns the FSM to IDLE with no stop pulse.

Structure
REQ-028 The FSM state encoding, the debounce counter width and the default parameter values belong in a shared package, slot_pkg.
REQ-029 One sub-module, btn_debounce (synchroniser, debounce counter and press-event detector), is instantiated twice.
REQ-030 slot_input sits upstream of the slot stage and drives its start and stop inputs, replacing direct button wiring.

Verification
REQ-031 Reset low, then released with both buttons idle -> start=stop=spinning=busy=0 and state IDLE.
REQ-032 With debounce_max=4: a start_btn_n glitch low for 3 cycles -> no start pulse; held low for 10 cycles -> exactly one start pulse, then spinning=1.
REQ-033 In IDLE, press stop -> no stop pulse; in SPIN, press start -> no start pulse.
REQ-034 With hold_cycles=5: SPIN, then stop press -> one stop pulse and busy=1 for 6 cycles; a start press during HOLD is ignored; a start press after HOLD -> a start pulse.
REQ-035 Both buttons press-accepted in the same cycle while in IDLE -> start only; while in SPIN -> stop only.
REQ-036 Reset asserted mid-SPIN while start is held low, then released -> state IDLE and no start pulse until release followed by a new press.

Source files
------------

// File: rtl/slot_pkg.sv
// slot_pkg: shared FSM encoding, counter width and default timing for the slot input block
package slot_pkg;
    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] DEBOUNCE_MAX_DEF = 32'h0000_0001;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [CNT_W-1:0] HOLD_CYCLES_DEF = 32'h0000_001E;
    typedef enum logic [1:0] {ST_IDLE, ST_SPIN, ST_HOLD} state_t;
endpackage

// File: rtl/slot_input_btn_debounce.sv
// btn_debounce: synchronises one active-low raw button, debounces it and flags accepted presses
module btn_debounce
    import slot_pkg::*;
#(
    parameter logic [CNT_W-1:0] debounce_max = DEBOUNCE_MAX_DEF,
    parameter int sync_stages = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);
    logic [sync_stages-1:0] r_sync;
    logic [sync_stages-1:0] r_vld;
    logic [CNT_W-1:0] r_cnt;
    logic r_acc;
    logic r_armed;
    logic w_lvl;
    logic w_vld;
    logic w_diff;
    logic w_take;
    logic [CNT_W-1:0] w_cnt_inc;
    assign w_lvl = ~r_sync[sync_stages-1];
    assign w_vld = r_vld[sync_stages-1];
    assign w_diff = w_lvl != r_acc;
    assign w_cnt_inc = (r_cnt >= debounce_max) ? debounce_max : r_cnt + 1'b1;
    assign w_take = w_diff && (w_cnt_inc >= debounce_max);
    assign o_press = w_take && w_lvl && r_armed;
    // r_vld tracks when the synchroniser holds real samples again after reset;
    // presses only count once a released level has been seen, so a button
    // held through reset must be let go before it can fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_vld   <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[sync_stages-2:0], i_btn_n};
            r_vld   <= {r_vld[sync_stages-2:0], 1'b1};
            r_cnt   <= (!w_diff || w_take) ? '0 : w_cnt_inc;
            r_acc   <= w_take ? w_lvl : r_acc;
            r_armed <= r_armed | (w_vld & ~w_lvl & ~r_acc);
        end
    end
endmodule

// File: rtl/slot_input.sv
// slot_input: debounced start/stop buttons driving an IDLE/SPIN/HOLD controller
// that issues single-cycle start and stop pulses to the slot stage.
module slot_input
    import slot_pkg::*;
#(
    parameter logic [CNT_W-1:0] debounce_max = DEBOUNCE_MAX_DEF,
    parameter int sync_stages = SYNC_STAGES_DEF,
    parameter logic [CNT_W-1:0] hold_cycles = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_btn_n,
    input  logic stop_btn_n,
    output logic start,
    output logic stop,
    output logic spinning,
    output logic busy
);
    state_t r_state;
    state_t w_state_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic w_start_ev;
    logic w_stop_ev;
    logic w_start_nxt;
    logic w_stop_nxt;

    btn_debounce #(.debounce_max(debounce_max), .sync_stages(sync_stages)) u_start (
        .clk(clk), .rst_n(reset), .i_btn_n(start_btn_n), .o_press(w_start_ev)
    );

    btn_debounce #(.debounce_max(debounce_max), .sync_stages(sync_stages)) u_stop (
        .clk(clk), .rst_n(reset), .i_btn_n(stop_btn_n), .o_press(w_stop_ev)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start_ev) begin
                w_start_nxt = 1'b1;
                w_state_nxt = ST_SPIN;
            end
            ST_SPIN: if (w_stop_ev) begin
                w_stop_nxt  = 1'b1;
                w_hold_nxt  = hold_cycles;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: if (r_hold == '0) w_state_nxt = ST_IDLE;
                     else w_hold_nxt = r_hold - 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_hold   <= '0;
            start    <= 1'b0;
            stop     <= 1'b0;
            spinning <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            start    <= w_start_nxt;
            stop     <= w_stop_nxt;
            spinning <= w_state_nxt == ST_SPIN;
            busy     <= w_state_nxt == ST_HOLD;
        end
    end
endmodule

// File: tb/tb_slot_input.sv
// tb_slot_input: directed button scenarios with hand-computed pulse counts for slot_input
module tb_slot_input;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_btn_n = 1'b1;
    logic stop_btn_n = 1'b1;
    logic start, stop, spinning, busy;
    int errors = 0;
    int checks = 0;
    int s_cnt = 0;
    int p_cnt = 0;
    int b_cnt = 0;
    int ov_cnt = 0;
    int b0;

    slot_input #(.debounce_max(32'd4), .sync_stages(2), .hold_cycles(32'd5)) dut (
        .clk(clk), .reset(reset), .start_btn_n(start_btn_n), .stop_btn_n(stop_btn_n),
        .start(start), .stop(stop), .spinning(spinning), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) s_cnt++;
        if (stop) p_cnt++;
        if (busy) b_cnt++;
        if (start && stop) ov_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_btn_n = 1'b0;
        tick(10);
        start_btn_n = 1'b1;
        tick(12);
    endtask

    initial begin
        #1 reset = 1'b0;
        tick(3);
        check("rst_start", start, 0);
        check("rst_stop", stop, 0);
        check("rst_spin", spinning, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick(4);
        check("idle_spin", spinning, 0);
        check("idle_busy", busy, 0);
        start_btn_n = 1'b0;
        tick(3);
        start_btn_n = 1'b1;
        tick(10);
        check("glitch_cnt", s_cnt, 0);
        check("glitch_spin", spinning, 0);
        stop_btn_n = 1'b0;
        tick(10);
        stop_btn_n = 1'b1;
        tick(10);
        check("idle_stop_cnt", p_cnt, 0);
        check("idle_stop_spin", spinning, 0);
        start_btn_n = 1'b0;
        tick(5);
        check("lat_early", s_cnt, 0);
        tick(2);
        check("lat_pulse", s_cnt, 1);
        tick(3);
        start_btn_n = 1'b1;
        tick(10);
        check("press_cnt", s_cnt, 1);
        check("press_spin", spinning, 1);
        check("press_busy", busy, 0);
        press_start();
        check("spin_start_cnt", s_cnt, 1);
        check("spin_still", spinning, 1);
        b0 = b_cnt;
        stop_btn_n = 1'b0;
        tick(2);
        start_btn_n = 1'b0;
        tick(8);
        stop_btn_n = 1'b1;
        tick(2);
        start_btn_n = 1'b1;
        tick(14);
        check("hold_stop_cnt", p_cnt, 1);
        check("hold_busy_len", b_cnt - b0, 6);
        check("hold_start_ign", s_cnt, 1);
        check("hold_end_spin", spinning, 0);
        check("hold_end_busy", busy, 0);
        press_start();
        check("after_hold_cnt", s_cnt, 2);
        check("after_hold_spin", spinning, 1);
        start_btn_n = 1'b0;
        stop_btn_n = 1'b0;
        tick(10);
        start_btn_n = 1'b1;
        stop_btn_n = 1'b1;
        tick(12);
        check("both_spin_stop", p_cnt, 2);
        check("both_spin_start", s_cnt, 2);
        check("both_spin_idle", spinning, 0);
        start_btn_n = 1'b0;
        stop_btn_n = 1'b0;
        tick(10);
        start_btn_n = 1'b1;
        stop_btn_n = 1'b1;
        tick(12);
        check("both_idle_start", s_cnt, 3);
        check("both_idle_stop", p_cnt, 2);
        check("both_idle_spin", spinning, 1);
        start_btn_n = 1'b0;
        tick(3);
        reset = 1'b0;
        #2;
        check("arst_spin", spinning, 0);
        check("arst_busy", busy, 0);
        tick(3);
        reset = 1'b1;
        tick(15);
        check("held_rst_cnt", s_cnt, 3);
        check("held_rst_stop", p_cnt, 2);
        check("held_rst_spin", spinning, 0);
        start_btn_n = 1'b1;
        tick(10);
        check("held_rel_cnt", s_cnt, 3);
        press_start();
        check("repress_cnt", s_cnt, 4);
        check("repress_spin", spinning, 1);
        check("no_overlap", ov_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
